// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the first-word-fall-through FIFO.
// Holds the pointer/count width function and the parameter legality check
// used at elaboration time by fifo_sync_fwft.
package fifo_pkg;

  // Pointers and the occupancy count carry one extra bit above the RAM
  // address, so FIFO_DEPTH itself is representable and full/empty never alias.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // True when the depth is a power of two (>= 4) and both flag thresholds
  // fall inside the range the count can actually reach.
  function automatic bit params_ok(input int depth, input int afull, input int aempty);
    return is_pow2(depth) && (depth >= 4) &&
           (afull >= 1) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/bram_infer.sv
// bram_infer: simple dual-port RAM, one write port and one read port on the
// same clock, with a registered read (one cycle latency). Contents and the
// read register are intentionally not reset so the array maps onto block RAM.
module bram_infer
  import fifo_pkg::*;
#(
  parameter int N_ADDR     = 64,
  parameter int DATA_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              we,
  input  logic [ptr_width(N_ADDR)-2:0]      waddr,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic                              re,
  input  logic [ptr_width(N_ADDR)-2:0]      raddr,
  output logic [DATA_WIDTH-1:0]             rdata
);

  logic [DATA_WIDTH-1:0] mem [N_ADDR];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port plus enabled read register; the read register holds its value
  // when re is low, which the FIFO relies on to park a prefetched word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_sync_fwft.sv
// fifo_sync_fwft: single-clock first-word-fall-through FIFO.
// Storage is a registered-read block RAM (bram_infer) followed by an output
// register; the RAM read register acts as a one-word prefetch stage, so a word
// written into an empty FIFO appears on rdata two edges later and a full
// stream runs at one word per cycle.
// Optional build macro: FIFO_PEAK_EN adds the peak_count output.
module fifo_sync_fwft
  import fifo_pkg::*;
#(
  parameter int DIN_WIDTH     = 16,
  parameter int FIFO_DEPTH    = 64,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 8,
  parameter int AEMPTY_THRESH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DIN_WIDTH-1:0]                 wdata,
  input  logic                                 w_valid,
  output logic                                 w_ready,
  output logic [DIN_WIDTH-1:0]                 rdata,
  output logic                                 r_valid,
  input  logic                                 r_ready,
  input  logic                                 flush,
  input  logic                                 clr_err,
  output logic [ptr_width(FIFO_DEPTH)-1:0]     count,
  output logic                                 empty,
  output logic                                 full,
  output logic                                 almost_full,
  output logic                                 almost_empty,
  output logic                                 overflow
`ifdef FIFO_PEAK_EN
  ,
  output logic [ptr_width(FIFO_DEPTH)-1:0]     peak_count
`endif
);

  localparam int CW = ptr_width(FIFO_DEPTH);
  localparam int AW = CW - 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  localparam bit PARAMS_OK = params_ok(FIFO_DEPTH, AFULL_THRESH, AEMPTY_THRESH);

  // Refuse to elaborate with a non power-of-two depth or unreachable thresholds.
  generate
    if (!PARAMS_OK) begin : g_param_check
      $error("fifo_sync_fwft: illegal FIFO_DEPTH or threshold parameters");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [CW-1:0]        wr_ptr_q,    wr_ptr_d;
  logic [CW-1:0]        rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0]        count_q,     count_d;
  logic                 mid_valid_q, mid_valid_d;  // RAM read register holds a word
  logic                 out_valid_q, out_valid_d;  // output register holds the head
  logic [DIN_WIDTH-1:0] rdata_q,     rdata_d;
  logic                 overflow_q,  overflow_d;

  // ---------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------
  logic                 full_w;
  logic                 accept;
  logic                 pop;
  logic                 ram_has_data;
  logic                 mid_to_out;
  logic                 rd_en;
  logic                 ovf_event;
  logic [DIN_WIDTH-1:0] ram_rdata;

  // Decode accepts, pops and prefetch moves; flush cancels every transfer.
  always_comb begin
    full_w       = (count_q == DEPTH_C);
    accept       = w_valid & ~full_w & ~flush;
    pop          = out_valid_q & r_ready & ~flush;
    // Words still in RAM and not yet moved into the read register.
    ram_has_data = (wr_ptr_q != rd_ptr_q);
    // The output register refills whenever it is empty or being popped.
    mid_to_out   = mid_valid_q & (~out_valid_q | pop);
    // Issue a RAM read whenever the read register is free or draining now.
    rd_en        = ram_has_data & (~mid_valid_q | mid_to_out) & ~flush;
    // A write attempt against a full FIFO is dropped and flagged, even if a
    // pop frees a slot on the same edge; a flush suppresses the flag.
    ovf_event    = w_valid & full_w & ~flush;
  end

  bram_infer #(
    .N_ADDR     (FIFO_DEPTH),
    .DATA_WIDTH (DIN_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------

  // Pointer advance; flush collapses both pointers back to zero.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + CW'(1);
      if (rd_en)  rd_ptr_d = rd_ptr_q + CW'(1);
    end
  end

  // Occupancy counts every accepted word until it is popped, including the
  // words sitting in the prefetch and output registers.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Prefetch and output register valids plus head data; the head only changes
  // when it is empty or popped, so it is stable under backpressure.
  always_comb begin
    mid_valid_d = mid_valid_q;
    out_valid_d = out_valid_q;
    rdata_d     = rdata_q;
    if (flush) begin
      mid_valid_d = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (rd_en) begin
        mid_valid_d = 1'b1;
      end else if (mid_to_out) begin
        mid_valid_d = 1'b0;
      end

      if (mid_to_out) begin
        out_valid_d = 1'b1;
        rdata_d     = ram_rdata;
      end else if (pop) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Sticky overflow; a new overflow event wins over a simultaneous clear.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_event) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mid_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      rdata_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mid_valid_q <= mid_valid_d;
      out_valid_q <= out_valid_d;
      rdata_q     <= rdata_d;
      overflow_q  <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: every flag is a decode of the registered count.
  // ---------------------------------------------------------------------
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = full_w;
  assign w_ready      = ~full_w;
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign r_valid      = out_valid_q;
  assign rdata        = rdata_q;
  assign overflow     = overflow_q;

`ifdef FIFO_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  // High-water mark of the count, one cycle behind it; clr_err restarts the
  // tracking from the current level.
  always_comb begin
    peak_d = peak_q;
    if (clr_err) begin
      peak_d = count_q;
    end else if (count_q > peak_q) begin
      peak_d = count_q;
    end
  end

  // Peak register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_count = peak_q;
`endif

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// tb_fifo_sync_fwft: directed, table-driven bench for fifo_sync_fwft with the
// default parameters (16-bit data, depth 64, almost_full at 56, almost_empty
// at 8), followed by hand-written multi-cycle sequences.
module tb_fifo_sync_fwft;

  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int CW    = 7;
  localparam int AF    = 56;
  localparam int AE    = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] wdata;
  logic          w_valid;
  logic          w_ready;
  logic [DW-1:0] rdata;
  logic          r_valid;
  logic          r_ready;
  logic          flush;
  logic          clr_err;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
`ifdef FIFO_PEAK_EN
  logic [CW-1:0] peak_count;
`endif

  fifo_sync_fwft #(
    .DIN_WIDTH     (DW),
    .FIFO_DEPTH    (DEPTH),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wdata        (wdata),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .rdata        (rdata),
    .r_valid      (r_valid),
    .r_ready      (r_ready),
    .flush        (flush),
    .clr_err      (clr_err),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow)
`ifdef FIFO_PEAK_EN
    ,
    .peak_count   (peak_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  typedef struct {
    logic          wv;
    logic [DW-1:0] wd;
    logic          rr;
    logic          fl;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    int            e_cnt;
  } vec_t;

  vec_t tbl[23];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: condition not met", name);
  endtask

  // Count-derived flags, expected from the bench's own occupancy figure.
  task automatic check_flags(input string name, input int exp_cnt);
    chk({name, ".count"},        32'(count),        32'(exp_cnt));
    chk({name, ".empty"},        32'(empty),        32'(exp_cnt == 0));
    chk({name, ".full"},         32'(full),         32'(exp_cnt == DEPTH));
    chk({name, ".w_ready"},      32'(w_ready),      32'(exp_cnt != DEPTH));
    chk({name, ".almost_full"},  32'(almost_full),  32'(exp_cnt >= AF));
    chk({name, ".almost_empty"}, 32'(almost_empty), 32'(exp_cnt <= AE));
  endtask

  // Writes n words base..base+n-1 into an empty FIFO with r_ready low.
  task automatic fill(input int n, input int base);
    w_valid = 1'b1;
    r_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      wdata = 16'(base + i);
      tick();
      check_flags($sformatf("fill%0d", i), i + 1);
    end
    w_valid = 1'b0;
  endtask

  // Pops n words with r_ready held high, expecting first, first+1, ...
  task automatic drain_expect(input string name, input int first, input int n, input int start_cnt);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    r_ready = 1'b1;
    while (got < n && cyc < n + 20) begin
      if (r_valid) begin
        chk($sformatf("%s.rdata%0d", name, got), 32'(rdata), 32'(16'(first + got)));
        got++;
      end
      tick();
      cyc++;
      check_flags($sformatf("%s.c%0d", name, cyc), start_cnt - got);
    end
    r_ready = 1'b0;
    chk({name, ".words"}, 32'(got), 32'(n));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, ".count"},        32'(count),        32'd0);
    chk({name, ".empty"},        32'(empty),        32'd1);
    chk({name, ".full"},         32'(full),         32'd0);
    chk({name, ".w_ready"},      32'(w_ready),      32'd1);
    chk({name, ".r_valid"},      32'(r_valid),      32'd0);
    chk({name, ".rdata"},        32'(rdata),        32'd0);
    chk({name, ".almost_empty"}, 32'(almost_empty), 32'd1);
    chk({name, ".almost_full"},  32'(almost_full),  32'd0);
    chk({name, ".overflow"},     32'(overflow),     32'd0);
`ifdef FIFO_PEAK_EN
    chk({name, ".peak_count"},   32'(peak_count),   32'd0);
`endif
  endtask

  initial begin
    logic [DW-1:0] q[$];
    int            cnt_m;
    int            got;
    int            cyc;
    logic          wv;
    logic          rr;
    logic [DW-1:0] wd;
    logic          acc;
    logic          pp;

    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    wdata   = '0;
    w_valid = 1'b0;
    r_ready = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;

    // {w_valid, wdata, r_ready, flush, exp r_valid, exp rdata, exp count}
    tbl[0]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1};
    tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1};
    tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1};
    tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 0};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 0};
    tbl[9]  = '{1'b1, 16'h0A0A, 1'b0, 1'b0, 1'b0, 16'h0000, 1};
    tbl[10] = '{1'b1, 16'h0B0B, 1'b0, 1'b0, 1'b0, 16'h0000, 2};
    tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0A0A, 2};
    tbl[12] = '{1'b1, 16'h0C0C, 1'b1, 1'b0, 1'b1, 16'h0B0B, 2};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0C0C, 1};
    tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 0};
    tbl[16] = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 1};
    tbl[17] = '{1'b1, 16'h9999, 1'b1, 1'b1, 1'b0, 16'h0000, 0};
    tbl[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0};
    tbl[19] = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0000, 1};
    tbl[20] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1};
    tbl[21] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h2222, 1};
    tbl[22] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 0};

    // Reset state, checked while reset is held and again after release.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    tick();
    check_reset_outputs("rst_rel");

    // Table: single word latency/hold/pop, empty pop, interleaving, flush.
    foreach (tbl[i]) begin
      w_valid = tbl[i].wv;
      wdata   = tbl[i].wd;
      r_ready = tbl[i].rr;
      flush   = tbl[i].fl;
      tick();
      $display("vec %0d: wv=%0d wd=%h rr=%0d fl=%0d -> rv=%0d rd=%h cnt=%0d",
               i, tbl[i].wv, tbl[i].wd, tbl[i].rr, tbl[i].fl, r_valid, rdata, count);
      chk($sformatf("v%0d.r_valid", i), 32'(r_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("v%0d.rdata", i), 32'(rdata), 32'(tbl[i].e_rd));
      check_flags($sformatf("v%0d", i), tbl[i].e_cnt);
      chk($sformatf("v%0d.overflow", i), 32'(overflow), 32'd0);
    end
    w_valid = 1'b0;
    r_ready = 1'b0;
    flush   = 1'b0;

    // Fill to full, then the full-boundary overflow cases.
    fill(DEPTH, 0);
    chk("full.head", 32'(rdata), 32'd0);
    // Write while full with a pop on the same edge: dropped, overflow set.
    w_valid = 1'b1; wdata = 16'hDEAD; r_ready = 1'b1;
    tick();
    check_flags("ovf_pop", DEPTH - 1);
    chk("ovf_pop.overflow", 32'(overflow), 32'd1);
    // Accepted write (not full) with clr_err: overflow clears.
    wdata = 16'(DEPTH); r_ready = 1'b0; clr_err = 1'b1;
    tick();
    check_flags("clr", DEPTH);
    chk("clr.overflow", 32'(overflow), 32'd0);
    // clr_err together with a write while full: set wins.
    wdata = 16'hDEA2;
    tick();
    check_flags("setwins", DEPTH);
    chk("setwins.overflow", 32'(overflow), 32'd1);
    w_valid = 1'b0; clr_err = 1'b0;
    drain_expect("drain", 1, DEPTH, DEPTH);
    chk("drain.overflow_sticky", 32'(overflow), 32'd1);

    // Flush with 20 words buffered and a simultaneous write and pop.
    fill(20, 16'h0100);
    tick();
    tick();
    chk("pre_flush.r_valid", 32'(r_valid), 32'd1);
    chk("pre_flush.rdata", 32'(rdata), 32'h0100);
    flush = 1'b1; w_valid = 1'b1; wdata = 16'h5555; r_ready = 1'b1;
    tick();
    flush = 1'b0; w_valid = 1'b0; r_ready = 1'b0;
    check_flags("flush", 0);
    chk("flush.r_valid", 32'(r_valid), 32'd0);
    chk("flush.overflow", 32'(overflow), 32'd1);
    tick();
    chk("flush2.r_valid", 32'(r_valid), 32'd0);
    w_valid = 1'b1; wdata = 16'hBEEF;
    tick();
    w_valid = 1'b0;
    cyc = 0;
    while (!r_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    if (!r_valid) fail_now("beef.timeout");
    chk("beef.rdata", 32'(rdata), 32'hBEEF);
    chk("beef.count", 32'(count), 32'd1);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk("beef.empty", 32'(empty), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr2.overflow", 32'(overflow), 32'd0);

    // Flush while full with a write attempt: no overflow.
    fill(DEPTH, 16'h0300);
    flush = 1'b1; w_valid = 1'b1; wdata = 16'h7777;
    tick();
    flush = 1'b0; w_valid = 1'b0;
    check_flags("flush_full", 0);
    chk("flush_full.overflow", 32'(overflow), 32'd0);
    chk("flush_full.r_valid", 32'(r_valid), 32'd0);

    // Streaming: 1000 cycles of simultaneous write and read.
    w_valid = 1'b1; r_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      wdata = 16'(k);
      tick();
      if (k >= 2) begin
        chk($sformatf("stream%0d.r_valid", k), 32'(r_valid), 32'd1);
        chk($sformatf("stream%0d.rdata", k), 32'(rdata), 32'(16'(k - 2)));
        chk($sformatf("stream%0d.count", k), 32'(count), 32'd3);
      end
    end
    w_valid = 1'b0;
    repeat (6) tick();
    r_ready = 1'b0;
    check_flags("stream_end", 0);

    // Random traffic against a queue scoreboard.
    cnt_m = 0;
    for (int c = 0; c < 10000; c++) begin
      chk("rnd.count", 32'(count), 32'(cnt_m));
      chk("rnd.w_ready", 32'(w_ready), 32'(cnt_m != DEPTH));
      wv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      w_valid = wv; r_ready = rr; wdata = wd;
      acc = wv && (cnt_m < DEPTH);
      pp  = r_valid && rr;
      if (pp) begin
        if (q.size() == 0) begin
          fail_now("rnd.spurious_pop");
        end else begin
          chk("rnd.rdata", 32'(rdata), 32'(q[0]));
          void'(q.pop_front());
        end
      end
      if (acc) q.push_back(wd);
      cnt_m = cnt_m + int'(acc) - int'(pp);
      tick();
    end
    w_valid = 1'b0;
    r_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      if (r_valid) begin
        chk("rnd_drain.rdata", 32'(rdata), 32'(q[0]));
        void'(q.pop_front());
        got++;
      end
      tick();
      cyc++;
    end
    r_ready = 1'b0;
    chk("rnd_drain.left", 32'(q.size()), 32'd0);
    check_flags("rnd_end", 0);

    // Asynchronous reset in the middle of a cycle with data and overflow set.
    fill(DEPTH, 16'h0200);
    w_valid = 1'b1; wdata = 16'hDEAD;
    tick();
    w_valid = 1'b0;
    chk("pre_rst.overflow", 32'(overflow), 32'd1);
    chk("pre_rst.rdata", 32'(rdata), 32'h0200);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    w_valid = 1'b1; wdata = 16'h0077;
    tick();
    w_valid = 1'b0;
    tick();
    tick();
    chk("post_rst.r_valid", 32'(r_valid), 32'd1);
    chk("post_rst.rdata", 32'(rdata), 32'h0077);
    check_flags("post_rst", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_sync_fwft.md
Name: fifo_sync_fwft

Overview:
Parametrised single-clock FIFO for the streaming datapaths. It generalises the existing request/answer sync FIFO to first-word-fall-through: the head word is presented on rdata with r_valid and is popped with r_ready. It adds an occupancy count, programmable almost-full and almost-empty flags, a synchronous flush and a sticky overflow flag. It sits between producer stages (e.g. correlator or vector accumulator outputs) and consumers that apply backpressure.

Parameters:
DIN_WIDTH, 16, data width in bits.
FIFO_DEPTH, 64, capacity in words; power of two, >=4.
AFULL_THRESH, FIFO_DEPTH-8, almost_full asserts when count >= this value; range 1..FIFO_DEPTH.
AEMPTY_THRESH, 8, almost_empty asserts when count <= this value; range 0..FIFO_DEPTH-1.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
wdata  in  DIN_WIDTH  write data.
w_valid  in  1  write request.
w_ready  out  1  equals ~full; a write is accepted when w_valid & w_ready.
rdata  out  DIN_WIDTH  head word, valid while r_valid=1.
r_valid  out  1  head word present.
r_ready  in  1  consumer pop; a pop happens when r_valid & r_ready.
flush  in  1  synchronous clear of contents.
clr_err  in  1  clears the overflow flag.
count  out  $clog2(FIFO_DEPTH)+1  words accepted and not yet popped.
empty  out  1  count==0.
full  out  1  count==FIFO_DEPTH.
almost_full  out  1  count>=AFULL_THRESH.
almost_empty  out  1  count<=AEMPTY_THRESH.
overflow  out  1  sticky; set by a write attempt while full.

Behaviour:
- Reset (async): count=0, empty=1, full=0, w_ready=1, r_valid=0, rdata=0, almost_empty=1, almost_full=0, overflow=0. RAM contents are not cleared.
- Storage is inferred dual-port BRAM with 1-cycle registered read, followed by a prefetch/output stage. Capacity is exactly FIFO_DEPTH words, counting words held in the output stage.
- Latency: a word accepted into an empty FIFO at edge N gives r_valid=1 with that word after edge N+2.
- Throughput: with w_valid=r_ready=1 continuously and a non-empty FIFO, one word per cycle is sustained with no bubbles.
- rdata and r_valid hold stable while r_valid & ~r_ready (no data change under backpressure).
- count is updated every edge: +1 on accept, -1 on pop, unchanged on both or neither. All flags derive from the count register, so they are valid in the same cycle as count.
- Full boundary: w_ready=~full is registered state. A write while full is not accepted even if a pop occurs in the same cycle. The word is dropped and overflow sets on the next edge.
- Empty boundary: r_valid=0; r_ready is ignored.
- Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally modulo 2*FIFO_DEPTH. There are no special cases at wrap.
- flush=1 at edge N: after N, count=0, r_valid=0, and pointers are equal. Any write or pop in cycle N is discarded and does not set overflow. flush has priority over everything except rst.
- clr_err: overflow clears on the next edge. If an overflow event occurs in the same cycle, set wins.
- A reset mid-stream discards all data. No output glitches beyond the asynchronous clear.

Optional Feature:
FIFO_PEAK_EN: when defined, adds output peak_count [$clog2(FIFO_DEPTH)+1] holding the maximum count seen since reset or since the last clr_err. It is updated one cycle after count, clears on rst, and on clr_err loads the current count. When undefined, the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- A shared package fifo_pkg holds the pointer-width function (clog2(depth)+1) and a localparam check that FIFO_DEPTH is a power of two and that both thresholds are in range.
- One natural sub-module: the existing bram_infer simple dual-port RAM (N_ADDR=FIFO_DEPTH, DATA_WIDTH=DIN_WIDTH). The prefetch/output stage stays in the top module.

Test Plan:
- Single word: write 0x1234 at cycle 0 into an empty FIFO (r_ready=0) -> r_valid=1, rdata=0x1234 at cycle 2, count=1; hold r_ready=0 for 5 cycles -> rdata stable. Pulse r_ready -> r_valid=0, empty=1.
- Fill, DEPTH=64: write 64 words 0..63 with r_ready=0 -> full=1, w_ready=0, almost_full from count 56. 65th write -> data dropped, overflow=1. Drain all -> read order 0..63, almost_empty=1 at count<=8.
- Streaming: w_valid=r_ready=1 for 1000 cycles with an incrementing pattern -> output is in order, has no gaps after the initial 2-cycle latency, and count is constant.
- Random w_valid/r_ready, 50% each, 10k cycles against a scoreboard -> no loss or duplication; count matches the model and wraps correctly across pointer wrap.
- Flush with count=20 plus a simultaneous write -> count=0, r_valid=0, overflow unchanged. The next written word 0xBEEF is the first word read.
- clr_err while overflow=1 -> overflow=0 next cycle. Assert rst asynchronously mid-stream -> all outputs immediately return to their reset values.
